modcount_updown: RTL and testbench

//  Parametrised up/down modulo counter; the next generation of the free-running
//  51-bit counter. Adds width and modulus parameters, enable, direction, parallel

---
 rtl/modcount_pkg.sv | 38 +++
 rtl/modcount_prescaler.sv | 55 +++++
 rtl/modcount_updown.sv | 117 +++++++++++
 tb/tb_modcount_updown.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modcount_pkg.sv
// -----------------------------------------------------------------------------
// modcount_pkg
//   Shared definitions for the modcount_updown counter family:
//     - dir_e          : count direction (DIR_UP = 1'b1, DIR_DN = 1'b0)
//     - modcount_max() : terminal value for a given WIDTH / MODULUS pair
//     - modcount_ps_w(): prescaler phase-counter width, $clog2(PRESCALE+1)
//     - PS_W           : phase-counter width for the default PRESCALE of 1
// -----------------------------------------------------------------------------
package modcount_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Largest value the counter may hold. MODULUS == 0 selects the full
    // 2**WIDTH range; the WIDTH == 64 case avoids shifting past the word size.
    function automatic logic [63:0] modcount_max(input int unsigned      width,
                                                 input longint unsigned modulus);
        logic [63:0] m;
        if (modulus != 0) begin
            m = 64'(modulus - 64'd1);
        end else if (width >= 64) begin
            m = '1;
        end else begin
            m = (64'd1 << width) - 64'd1;
        end
        return m;
    endfunction

    // Width of the prescaler phase counter for a given PRESCALE.
    function automatic int unsigned modcount_ps_w(input int unsigned prescale);
        return $clog2(prescale + 1);
    endfunction

    localparam int unsigned PS_W = modcount_ps_w(1);

endpackage : modcount_pkg

// File: rtl/modcount_prescaler.sv
// -----------------------------------------------------------------------------
// modcount_prescaler
//   Cycle divider for modcount_updown. Emits a one-cycle step every PRESCALE
//   enabled cycles. The phase counter advances only while en = 1 and is
//   returned to zero by reset or clr (clr is the parent's parallel load).
//
//   Parameters
//     PRESCALE  1..65535  enabled cycles per step
//     CNT_W     phase counter width, $clog2(PRESCALE+1)
//
//   Ports
//     clk    in   rising-edge clock
//     reset  in   synchronous active-high reset
//     clr    in   synchronous phase clear
//     en     in   count enable
//     step   out  combinational step request (en & phase == PRESCALE-1)
// -----------------------------------------------------------------------------
module modcount_prescaler
    import modcount_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CNT_W    = modcount_ps_w(PRESCALE)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;

    assign step = en & (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = step ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule : modcount_prescaler

// File: rtl/modcount_updown.sv
// -----------------------------------------------------------------------------
// modcount_updown
//   Parametrised up/down modulo counter with enable, parallel load, cycle
//   prescaler and terminal-count / wrap flags.
//
//   Parameters
//     WIDTH     1..64   counter width
//     MODULUS   count range 0..MODULUS-1, 0 = full 2**WIDTH range
//     PRESCALE  1..65535 enabled cycles per step
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   synchronous active-high reset (beats load and en)
//     en        in   count enable, also gates the prescaler
//     up_dn     in   1 = up, 0 = down, sampled every cycle
//     load      in   parallel load strobe (beats stepping)
//     load_val  in   load value, clamped to MAX
//     out       out  registered count
//     tc        out  combinational terminal count for the current direction
//     wrap      out  registered one-cycle pulse on a wrapping step
//
//   Build option
//     MODCOUNT_SATURATE_EN : steps at a bound hold the bound instead of
//                            wrapping; wrap then pulses on each such attempt.
// -----------------------------------------------------------------------------
module modcount_updown
    import modcount_pkg::*;
#(
    parameter int unsigned     WIDTH    = 51,
    parameter longint unsigned MODULUS  = 0,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(modcount_max(WIDTH, MODULUS));
    localparam int unsigned      CNT_W = modcount_ps_w(PRESCALE);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             dir_up;

    modcount_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (en),
        .step  (step)
    );

    assign dir_up  = (up_dn == DIR_UP);
    assign at_max  = (cnt_q == MAX);
    assign at_zero = (cnt_q == '0);

    assign out  = cnt_q;
    assign tc   = dir_up ? at_max : at_zero;
    assign wrap = wrap_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = (load_val > MAX) ? MAX : load_val;
        end else if (step) begin
            if (dir_up) begin
                if (at_max) begin
`ifdef MODCOUNT_SATURATE_EN
                    cnt_d  = cnt_q;
`else
                    cnt_d  = '0;
`endif
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
`ifdef MODCOUNT_SATURATE_EN
                    cnt_d  = cnt_q;
`else
                    cnt_d  = MAX;
`endif
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

endmodule : modcount_updown

// File: tb/tb_modcount_updown.sv
module tb_modcount_updown;

    localparam int NDUT = 3;
    // Instance 0: W4 M10 P1, instance 1: W4 M10 P3, instance 2: W4 M0 P1.
    localparam int MODS [NDUT] = '{10, 10, 16};
    localparam int PRES [NDUT] = '{1, 3, 1};

`ifdef MODCOUNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] out_a  [NDUT];
    logic       tc_a   [NDUT];
    logic       wrap_a [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: count, prescaler phase, wrap flag.
    int mc [NDUT];
    int mp [NDUT];
    int mw [NDUT];

    always #5 clk = ~clk;

    modcount_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .out(out_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0]));

    modcount_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .out(out_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1]));

    modcount_updown #(.WIDTH(4), .MODULUS(0), .PRESCALE(1)) u_full (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .out(out_a[2]), .tc(tc_a[2]), .wrap(wrap_a[2]));

    // Advance one clock and apply the behavioural rules to every model.
    task automatic step_clk();
        int nxt;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                mc[k] = 0; mp[k] = 0; mw[k] = 0;
            end else if (load) begin
                mc[k] = (int'(load_val) > MODS[k] - 1) ? MODS[k] - 1 : int'(load_val);
                mp[k] = 0; mw[k] = 0;
            end else begin
                mw[k] = 0;
                if (en) begin
                    if (mp[k] == PRES[k] - 1) begin
                        mp[k] = 0;
                        nxt = up_dn ? mc[k] + 1 : mc[k] - 1;
                        if (nxt < 0 || nxt >= MODS[k]) begin
                            mw[k] = 1;
                            if (!SAT) mc[k] = (nxt + MODS[k]) % MODS[k];
                        end else begin
                            mc[k] = nxt;
                        end
                    end else begin
                        mp[k] = mp[k] + 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; en = 1; up_dn = 1; load = 0; load_val = 4'd0;
        step_clk();
        reset = 0; en = 0;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (out_a[k] !== 4'd0 || wrap_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: out=%0d wrap=%b, want out=0 wrap=0", k, out_a[k], wrap_a[k]);
            end
        end
        up_dn = 0; #1;
        n_checks++;
        if (tc_a[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_tc_down: tc=%b want 1", tc_a[0]);
        end
        up_dn = 1; #1;
        n_checks++;
        if (tc_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_tc_up: tc=%b want 0", tc_a[0]);
        end
    endtask

    task automatic test_count_up();
        int exp_o [12];
        int exp_w [12];
        for (int i = 0; i < 12; i++) begin
            exp_o[i] = SAT ? ((i + 1 > 9) ? 9 : i + 1) : (i + 1) % 10;
            exp_w[i] = SAT ? int'(i >= 9) : int'(i == 9);
        end
        en = 1; up_dn = 1;
        for (int i = 0; i < 12; i++) begin
            step_clk();
            n_checks++;
            if (out_a[0] !== 4'(exp_o[i]) || wrap_a[0] !== 1'(exp_w[i]) ||
                tc_a[0] !== (exp_o[i] == 9)) begin
                n_fail++;
                $display("FAIL count_up[%0d]: out=%0d wrap=%b tc=%b, want out=%0d wrap=%0d tc=%0d",
                         i, out_a[0], wrap_a[0], tc_a[0], exp_o[i], exp_w[i], exp_o[i] == 9);
            end
        end
        en = 0;
    endtask

    task automatic test_count_down();
        int exp_o [5];
        exp_o = SAT ? '{3, 2, 1, 0, 0} : '{3, 2, 1, 0, 9};
        load = 1; load_val = 4'd3; en = 0; up_dn = 0;
        step_clk();
        load = 0; en = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step_clk();
            n_checks++;
            if (out_a[0] !== 4'(exp_o[i]) || wrap_a[0] !== (i == 4) ||
                tc_a[0] !== (exp_o[i] == 0)) begin
                n_fail++;
                $display("FAIL count_down[%0d]: out=%0d wrap=%b tc=%b, want out=%0d wrap=%0d tc=%0d",
                         i, out_a[0], wrap_a[0], tc_a[0], exp_o[i], i == 4, exp_o[i] == 0);
            end
        end
        en = 0;
    endtask

    task automatic test_load_clamp();
        load = 1; load_val = 4'd12; en = 0; up_dn = 1;
        step_clk();
        n_checks++;
        if (out_a[0] !== 4'd9) begin
            n_fail++; $display("FAIL load_clamp: out=%0d want 9", out_a[0]);
        end
        n_checks++;
        if (out_a[2] !== 4'd12) begin
            n_fail++; $display("FAIL load_full_range: out=%0d want 12", out_a[2]);
        end
        load_val = 4'd5; en = 1;
        step_clk();
        load = 0; en = 0;
        n_checks++;
        if (out_a[0] !== 4'd5 || wrap_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL load_with_en: out=%0d wrap=%b want 5/0", out_a[0], wrap_a[0]);
        end
        step_clk();
        n_checks++;
        if (out_a[0] !== 4'd5) begin
            n_fail++; $display("FAIL hold: out=%0d want 5", out_a[0]);
        end
    endtask

    task automatic test_prescale();
        // enable pattern after reset and expected u_p3 count after each cycle
        int pat_en [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
        int pat_o  [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3};
        reset = 1; load = 0; up_dn = 1;
        step_clk();
        reset = 0;
        for (int i = 0; i < 12; i++) begin
            en = 1'(pat_en[i]);
            step_clk();
            n_checks++;
            if (out_a[1] !== 4'(pat_o[i])) begin
                n_fail++; $display("FAIL prescale[%0d]: out=%0d want %0d", i, out_a[1], pat_o[i]);
            end
        end
        // phase is now 1; load must restart it from 0
        load = 1; load_val = 4'd5; en = 1;
        step_clk();
        load = 0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            n_checks++;
            if (out_a[1] !== ((i == 2) ? 4'd6 : 4'd5)) begin
                n_fail++; $display("FAIL prescale_load[%0d]: out=%0d want %0d", i, out_a[1], (i == 2) ? 6 : 5);
            end
        end
        en = 0;
    endtask

    task automatic test_reset_priority();
        reset = 1; step_clk(); reset = 0;
        en = 1; up_dn = 1;
        repeat (7) step_clk();
        n_checks++;
        if (out_a[0] !== 4'd7) begin
            n_fail++; $display("FAIL pre_reset: out=%0d want 7", out_a[0]);
        end
        reset = 1; load = 1; load_val = 4'd4;
        step_clk();
        reset = 0; load = 0; en = 0;
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (out_a[k] !== 4'd0 || wrap_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_priority[%0d]: out=%0d wrap=%b want 0/0", k, out_a[k], wrap_a[k]);
            end
        end
    endtask

    task automatic test_bounds();
        int up_o [3];
        int dn_o [2];
        up_o = SAT ? '{9, 9, 9} : '{9, 0, 1};
        dn_o = SAT ? '{0, 0} : '{0, 9};
        load = 1; load_val = 4'd8; en = 0; step_clk();
        load = 0; en = 1; up_dn = 1;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            n_checks++;
            if (out_a[0] !== 4'(up_o[i]) || wrap_a[0] !== (SAT ? (i > 0) : (i == 1))) begin
                n_fail++;
                $display("FAIL bound_up[%0d]: out=%0d wrap=%b want out=%0d", i, out_a[0], wrap_a[0], up_o[i]);
            end
        end
        load = 1; load_val = 4'd1; en = 0; step_clk();
        load = 0; en = 1; up_dn = 0;
        for (int i = 0; i < 2; i++) begin
            step_clk();
            n_checks++;
            if (out_a[0] !== 4'(dn_o[i]) || wrap_a[0] !== (i == 1)) begin
                n_fail++;
                $display("FAIL bound_down[%0d]: out=%0d wrap=%b want out=%0d wrap=%0d",
                         i, out_a[0], wrap_a[0], dn_o[i], i == 1);
            end
        end
        en = 0;
    endtask

    task automatic test_random();
        int exp_tc;
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 9) < 7);
            up_dn    = 1'($urandom_range(0, 1));
            load_val = 4'($urandom_range(0, 15));
            step_clk();
            for (int k = 0; k < NDUT; k++) begin
                exp_tc = up_dn ? int'(mc[k] == MODS[k] - 1) : int'(mc[k] == 0);
                n_checks++;
                if (out_a[k] !== 4'(mc[k]) || wrap_a[k] !== 1'(mw[k]) || tc_a[k] !== 1'(exp_tc)) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: out=%0d wrap=%b tc=%b, want out=%0d wrap=%0d tc=%0d",
                             c, k, out_a[k], wrap_a[k], tc_a[k], mc[k], mw[k], exp_tc);
                end
            end
        end
        reset = 0; load = 0; en = 0;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            mc[k] = 0; mp[k] = 0; mw[k] = 0;
        end
        reset = 1; en = 0; up_dn = 1; load = 0; load_val = 4'd0;
        @(negedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_prescale();
        test_reset_priority();
        test_bounds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_modcount_updown
